// File: rtl/uncater.sv
// uncater: receive-side unpacker for scrambled 4-bit cat symbols.
// Each accepted symbol is descrambled with the key bits a/b
// (c = cat_in ^ {4{a}}, valid only when a != b) and then unpacked:
// c[3] = start of frame, c[2:1] = two x bits, c[0] = one y bit.
// WIDTH/2 symbols make one frame, shifted in MSB first.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   cat_in/cat_valid     scrambled symbol stream
//   cat_ready            high in IDLE/COLLECT, low while a frame is held
//   a, b                 per-link key bits, sampled with each symbol
//   x, y                 last completed frame (y zero-extended)
//   out_valid/out_ready  output handshake for x/y
//   err                  one-cycle pulse per resync or key-error symbol
module uncater #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       cat_in,
  input  logic             cat_valid,
  output logic             cat_ready,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(HALF) + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  // The accumulators keep only the bits of earlier symbols; the symbol that
  // completes a frame is merged straight into x/y.
  logic [WIDTH-3:0] x_acc;
  logic [HALF-2:0]  y_acc;

  logic [3:0]       c;
  logic             sof;
  logic             accept;
  logic             key_ok;
  logic [WIDTH-1:0] x_shift;
  logic [HALF-1:0]  y_shift;

  logic load_first;
  logic do_shift;
  logic do_complete;
  logic do_clear;
  logic set_err;

  assign c       = cat_in ^ {4{a}};
  assign sof     = c[3];
  assign key_ok  = a ^ b;
  assign accept  = cat_valid && cat_ready;
  assign x_shift = {x_acc, c[2:1]};
  assign y_shift = {y_acc, c[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    cat_ready   = 1'b1;
    out_valid   = 1'b0;
    load_first  = 1'b0;
    do_shift    = 1'b0;
    do_complete = 1'b0;
    do_clear    = 1'b0;
    set_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!key_ok) begin
            set_err  = 1'b1;
            do_clear = 1'b1;
          end else if (sof) begin
            load_first = 1'b1;
            state_n    = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          // Key error outranks a resync on the same symbol.
          if (!key_ok) begin
            set_err  = 1'b1;
            do_clear = 1'b1;
            state_n  = IDLE;
          end else if (sof) begin
            set_err    = 1'b1;
            load_first = 1'b1;
          end else if (cnt == CW'(HALF - 1)) begin
            do_complete = 1'b1;
            state_n     = HOLD;
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      HOLD: begin
        cat_ready = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      x_acc <= '0;
      y_acc <= '0;
      x     <= '0;
      y     <= '0;
      err   <= 1'b0;
    end else begin
      err <= set_err;
      if (load_first) begin
        cnt   <= CW'(1);
        x_acc <= (WIDTH-2)'(c[2:1]);
        y_acc <= (HALF-1)'(c[0]);
      end else if (do_shift) begin
        cnt   <= cnt + CW'(1);
        x_acc <= x_shift[WIDTH-3:0];
        y_acc <= y_shift[HALF-2:0];
      end else if (do_complete) begin
        cnt <= '0;
        x   <= x_shift;
        y   <= {{HALF{1'b0}}, y_shift};
      end else if (do_clear) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uncater.sv
// Scoreboard bench for uncater (WIDTH=8). Stimulus pushes the expected
// x/y pair for every frame it sends; a monitor pops and compares on each
// out_valid/out_ready handshake and also tallies err pulses and
// cat_ready-low cycles for the scenario checks.
module tb_uncater;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       cat_in;
  logic             cat_valid;
  logic             cat_ready;
  logic             a;
  logic             b;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  uncater #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cat_in    (cat_in),
    .cat_valid (cat_valid),
    .cat_ready (cat_ready),
    .a         (a),
    .b         (b),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int err_seen;
  int ready_low;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-low-phase, after stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (err) err_seen++;
      if (!cat_ready) ready_low++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {x, y}, 16'h0000);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("frame_x", {24'h0, x}, {24'h0, e[15:8]});
          check("frame_y", {24'h0, y}, {24'h0, e[7:0]});
        end
      end
    end
  end

  task automatic send_sym(input logic [3:0] s, input logic ka, input logic kb);
    int n;
    @(negedge clk);
    cat_in    = s;
    a         = ka;
    b         = kb;
    cat_valid = 1'b1;
    n = 0;
    while (!cat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cat_ready) check("cat_ready_wait", {31'h0, cat_ready}, 32'h1);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    cat_valid = 1'b0;
  endtask

  // Nominal frame, a=1 b=0: descrambles to D,6,3,1 -> x=B4, y=0B.
  task automatic send_frame(input logic expect_out);
    if (expect_out) exp_q.push_back(16'hB40B);
    send_sym(4'h2, 1'b1, 1'b0);
    send_sym(4'h9, 1'b1, 1'b0);
    send_sym(4'hC, 1'b1, 1'b0);
    send_sym(4'hE, 1'b1, 1'b0);
    idle_in();
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int r0;
    tests     = 0;
    fails     = 0;
    err_seen  = 0;
    ready_low = 0;
    rst_n     = 1'b0;
    cat_in    = 4'h0;
    cat_valid = 1'b0;
    a         = 1'b0;
    b         = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("reset_x", {24'h0, x}, 32'h0);
    check("reset_y", {24'h0, y}, 32'h0);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_cat_ready", {31'h0, cat_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal back-to-back frame.
    e0 = err_seen; r0 = ready_low;
    send_frame(1'b1);
    drain();
    check("nominal_err_count", err_seen - e0, 32'd0);
    check("nominal_ready_low", ready_low - r0, 32'd1);

    // Backpressure: hold the frame for 5 cycles.
    out_ready = 1'b0;
    exp_q.push_back(16'hB40B);
    send_frame(1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_cat_ready", {31'h0, cat_ready}, 32'h0);
      check("bp_x", {24'h0, x}, 32'hB4);
      check("bp_y", {24'h0, y}, 32'h0B);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_out_valid", {31'h0, out_valid}, 32'h0);
    check("bp_release_cat_ready", {31'h0, cat_ready}, 32'h1);
    check("bp_x_kept", {24'h0, x}, 32'hB4);
    drain();

    // Pre-sof garbage is dropped silently.
    e0 = err_seen;
    send_sym(4'hA, 1'b1, 1'b0);
    send_frame(1'b1);
    drain();
    check("garbage_err_count", err_seen - e0, 32'd0);

    // Resync: partial frame abandoned by a new sof.
    e0 = err_seen;
    send_sym(4'h2, 1'b1, 1'b0);
    send_sym(4'h9, 1'b1, 1'b0);
    send_frame(1'b1);
    drain();
    check("resync_err_count", err_seen - e0, 32'd1);

    // Key error on the third symbol; trailing symbol falls into IDLE.
    e0 = err_seen;
    send_sym(4'h2, 1'b1, 1'b0);
    send_sym(4'h9, 1'b1, 1'b0);
    send_sym(4'hC, 1'b1, 1'b1);
    send_sym(4'hE, 1'b1, 1'b0);
    idle_in();
    drain();
    check("keyerr_err_count", err_seen - e0, 32'd1);
    check("keyerr_no_frame", exp_q.size(), 32'd0);
    send_frame(1'b1);
    drain();

    // Async reset mid-COLLECT.
    send_sym(4'h2, 1'b1, 1'b0);
    send_sym(4'h9, 1'b1, 1'b0);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_collect_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_collect_x", {24'h0, x}, 32'h0);
    check("rst_collect_cat_ready", {31'h0, cat_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b1);
    drain();

    // Async reset while holding a frame.
    out_ready = 1'b0;
    send_frame(1'b0);
    @(negedge clk);
    #1;
    check("hold_before_rst", {31'h0, out_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_hold_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_hold_x", {24'h0, x}, 32'h0);
    check("rst_hold_y", {24'h0, y}, 32'h0);
    check("rst_hold_cat_ready", {31'h0, cat_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(1'b1);
    drain();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
